// File: rtl/sdpram_read_checker.sv
// sdpram_read_checker
//   Scans every address of a simple-dual-port RAM read port once and checks
//   the returned data against an alternating pattern. Even addresses must read
//   all zeros and odd addresses all ones. Mismatches are counted (saturating)
//   and the address of the first mismatch is kept.
//
// Parameters
//   ADDR_WIDTH  RAM address width (4..10)
//   DATA_WIDTH  RAM data width (1..256)
//   OUT_REG     1 = RAM output registered (read latency 2), 0 = latency 1
//
// Ports
//   rd_clk_tb       read-side clock, rising edge
//   tb_rst          asynchronous active-high reset
//   start           one-cycle pulse, begins a scan when idle
//   abort           cancels a scan in progress (wins over start in IDLE)
//   rd_addr         registered RAM read address
//   rd_data         RAM read data
//   busy            high while scanning or draining the read pipeline
//   done            one-cycle pulse when a scan completes
//   pass            result of the last completed scan
//   err_cnt         mismatch count of the current or last scan
//   first_err_addr  address of the first mismatch of the scan
module sdpram_read_checker #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8,
  parameter int OUT_REG    = 1
) (
  input  logic                  rd_clk_tb,
  input  logic                  tb_rst,
  input  logic                  start,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           err_cnt,
  output logic [ADDR_WIDTH-1:0] first_err_addr
);

  localparam int                    RD_LAT     = 1 + OUT_REG;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [1:0]            DRAIN_LAST = 2'(RD_LAT - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t                  state;
  logic [1:0]              drain_cnt;

  logic                    vld_p0;
  logic                    vld_p1;
  logic [ADDR_WIDTH-1:0]   tag_p0;
  logic [ADDR_WIDTH-1:0]   tag_p1;

  logic                    in_scan;
  logic                    abort_hit;
  logic                    vld_cmp;
  logic [ADDR_WIDTH-1:0]   tag_cmp;
  logic                    mismatch;
  logic [15:0]             err_cnt_nxt;

  // Expected word for an address: every bit equals the address LSB.
  function automatic logic [DATA_WIDTH-1:0] exp_data(input logic addr_lsb);
    return {DATA_WIDTH{addr_lsb}};
  endfunction

  // Saturating increment of the mismatch counter.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign in_scan   = (state == SCAN) || (state == DRAIN);
  assign abort_hit = abort && in_scan;

  // The tag that lines up with rd_data sits at the end of an RD_LAT-deep pipe.
  assign vld_cmp     = (OUT_REG != 0) ? vld_p1 : vld_p0;
  assign tag_cmp     = (OUT_REG != 0) ? tag_p1 : tag_p0;
  assign mismatch    = vld_cmp && (rd_data != exp_data(tag_cmp[0]));
  assign err_cnt_nxt = mismatch ? sat_inc(err_cnt) : err_cnt;

  // ---- p0/p1: address-issue valids (control, reset and flushed on abort) ----
  always_ff @(posedge rd_clk_tb or posedge tb_rst) begin
    if (tb_rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else if (abort_hit) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p0 <= (state == SCAN);
      vld_p1 <= vld_p0;
    end
  end

  // ---- p0/p1: address tags travelling with the valids (data, no reset) ----
  always_ff @(posedge rd_clk_tb) begin
    tag_p0 <= rd_addr;
    tag_p1 <= tag_p0;
  end

  // ---- Control FSM with registered outputs; compare happens at pipe end ----
  always_ff @(posedge rd_clk_tb or posedge tb_rst) begin
    if (tb_rst) begin
      state          <= IDLE;
      drain_cnt      <= 2'd0;
      rd_addr        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_cnt        <= 16'd0;
      first_err_addr <= '0;
    end else begin
      done <= 1'b0;

      // An aborted cycle's compare is dropped so err_cnt freezes.
      if (in_scan && !abort) begin
        err_cnt <= err_cnt_nxt;
        if (mismatch && (err_cnt == 16'd0)) first_err_addr <= tag_cmp;
      end

      case (state)
        IDLE: begin
          if (start && !abort) begin
            state          <= SCAN;
            rd_addr        <= '0;
            err_cnt        <= 16'd0;
            first_err_addr <= '0;
            pass           <= 1'b0;
            busy           <= 1'b1;
          end
        end
        SCAN: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            pass  <= 1'b0;
          end else if (rd_addr == LAST_ADDR) begin
            // Hold the last address while its data works through the RAM.
            state     <= DRAIN;
            drain_cnt <= 2'd0;
          end else begin
            rd_addr <= rd_addr + ADDR_ONE;
          end
        end
        DRAIN: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            pass  <= 1'b0;
          end else if (drain_cnt == DRAIN_LAST) begin
            // The final compare lands on this edge, so use the updated count.
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_cnt_nxt == 16'd0);
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdpram_read_checker.sv
module tb_sdpram_read_checker;

  logic rd_clk_tb = 1'b0;
  logic tb_rst    = 1'b1;
  always #5 rd_clk_tb = ~rd_clk_tb;

  // DUT A: 1024 x 8, registered RAM output
  logic        start_a = 1'b0, abort_a = 1'b0;
  logic [9:0]  rd_addr_a;
  logic [7:0]  rd_data_a;
  logic        busy_a, done_a, pass_a;
  logic [15:0] err_cnt_a;
  logic [9:0]  first_a;

  // DUT B: 16 x 8, unregistered RAM output
  logic        start_b = 1'b0, abort_b = 1'b0;
  logic [3:0]  rd_addr_b;
  logic [7:0]  rd_data_b;
  logic        busy_b, done_b, pass_b;
  logic [15:0] err_cnt_b;
  logic [3:0]  first_b;

  sdpram_read_checker #(.ADDR_WIDTH(10), .DATA_WIDTH(8), .OUT_REG(1)) dut_a (
    .rd_clk_tb(rd_clk_tb), .tb_rst(tb_rst), .start(start_a), .abort(abort_a),
    .rd_addr(rd_addr_a), .rd_data(rd_data_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .err_cnt(err_cnt_a), .first_err_addr(first_a));

  sdpram_read_checker #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .OUT_REG(0)) dut_b (
    .rd_clk_tb(rd_clk_tb), .tb_rst(tb_rst), .start(start_b), .abort(abort_b),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .err_cnt(err_cnt_b), .first_err_addr(first_b));

  // RAM models: A has a two-cycle read (array + output register), B one cycle.
  logic [7:0] ram_a [1024];
  logic [7:0] ram_b [16];
  logic [7:0] a_q1;
  always @(posedge rd_clk_tb) begin
    a_q1      <= ram_a[rd_addr_a];
    rd_data_a <= a_q1;
    rd_data_b <= ram_b[rd_addr_b];
  end

  int n_checks = 0;
  int n_errors = 0;
  int dones_a  = 0;
  int dones_b  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic        pass;
    logic [15:0] errs;
    logic [9:0]  first;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;

  function automatic exp_t model_a();
    exp_t r;
    logic [7:0] want;
    r = '0;
    for (int a = 0; a < 1024; a++) begin
      want = a[0] ? 8'hFF : 8'h00;
      if (ram_a[a] != want) begin
        if (r.errs == 16'd0) r.first = 10'(a);
        r.errs = r.errs + 16'd1;
      end
    end
    r.pass = (r.errs == 16'd0);
    return r;
  endfunction

  function automatic exp_t model_b();
    exp_t r;
    logic [7:0] want;
    r = '0;
    for (int a = 0; a < 16; a++) begin
      want = a[0] ? 8'hFF : 8'h00;
      if (ram_b[a] != want) begin
        if (r.errs == 16'd0) r.first = 10'(a);
        r.errs = r.errs + 16'd1;
      end
    end
    r.pass = (r.errs == 16'd0);
    return r;
  endfunction

  // Scoreboard: each done pulse pops the expectation pushed at start time.
  always @(negedge rd_clk_tb) begin
    if (done_a) begin
      dones_a++;
      if (q_a.size() == 0) chk("done_a_unexpected", 32'd1, 32'd0);
      else begin
        ea = q_a.pop_front();
        chk("pass_a", pass_a, ea.pass);
        chk("err_cnt_a", err_cnt_a, ea.errs);
        chk("first_err_a", first_a, ea.first);
      end
    end
    if (done_b) begin
      dones_b++;
      if (q_b.size() == 0) chk("done_b_unexpected", 32'd1, 32'd0);
      else begin
        eb = q_b.pop_front();
        chk("pass_b", pass_b, eb.pass);
        chk("err_cnt_b", err_cnt_b, eb.errs);
        chk("first_err_b", first_b, eb.first);
      end
    end
  end

  task automatic fill_alt_a();
    for (int a = 0; a < 1024; a++) ram_a[a] = a[0] ? 8'hFF : 8'h00;
  endtask

  task automatic fill_alt_b();
    for (int a = 0; a < 16; a++) ram_b[a] = a[0] ? 8'hFF : 8'h00;
  endtask

  task automatic run_a(input string tag, input int exp_busy);
    int bcnt = 0;
    int cyc  = 0;
    bit seen = 0;
    q_a.push_back(model_a());
    start_a = 1'b1;
    @(negedge rd_clk_tb);
    start_a = 1'b0;
    while (!seen && cyc < 3000) begin
      if (busy_a) bcnt++;
      if (done_a) seen = 1;
      cyc++;
      if (!seen) @(negedge rd_clk_tb);
    end
    chk({tag, "_done_seen"}, seen, 1);
    chk({tag, "_busy_cycles"}, bcnt, exp_busy);
    @(negedge rd_clk_tb);
    chk({tag, "_done_one_cycle"}, done_a, 0);
  endtask

  task automatic run_b(input string tag, input int exp_busy);
    int bcnt = 0;
    int cyc  = 0;
    bit seen = 0;
    q_b.push_back(model_b());
    start_b = 1'b1;
    @(negedge rd_clk_tb);
    start_b = 1'b0;
    while (!seen && cyc < 200) begin
      if (busy_b) bcnt++;
      if (done_b) seen = 1;
      cyc++;
      if (!seen) @(negedge rd_clk_tb);
    end
    chk({tag, "_done_seen"}, seen, 1);
    chk({tag, "_busy_cycles"}, bcnt, exp_busy);
    @(negedge rd_clk_tb);
  endtask

  task automatic wait_addr_a(input int target);
    int n = 0;
    while (rd_addr_a != 10'(target) && n < 2000) begin
      @(negedge rd_clk_tb);
      n++;
    end
    if (n >= 2000) chk("wait_addr_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    fill_alt_a();
    fill_alt_b();

    // Reset state
    repeat (3) @(negedge rd_clk_tb);
    chk("rst_rd_addr", rd_addr_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_pass", pass_a, 0);
    chk("rst_err_cnt", err_cnt_a, 0);
    chk("rst_first", first_a, 0);
    tb_rst = 1'b0;
    @(negedge rd_clk_tb);

    // Clean alternating pattern
    run_a("alt", 1026);

    // Two corrupted words
    ram_a[6] = 8'h01;
    ram_a[9] = 8'h00;
    run_a("corrupt", 1026);
    fill_alt_a();

    // start and abort together in IDLE: abort wins
    start_a = 1'b1;
    abort_a = 1'b1;
    @(negedge rd_clk_tb);
    start_a = 1'b0;
    abort_a = 1'b0;
    chk("start_abort_busy", busy_a, 0);
    @(negedge rd_clk_tb);
    chk("start_abort_busy2", busy_a, 0);

    // Abort mid-scan at address 300
    start_a = 1'b1;
    @(negedge rd_clk_tb);
    start_a = 1'b0;
    wait_addr_a(300);
    chk("abort_pre_busy", busy_a, 1);
    abort_a = 1'b1;
    @(negedge rd_clk_tb);
    abort_a = 1'b0;
    chk("abort_busy", busy_a, 0);
    chk("abort_pass", pass_a, 0);
    chk("abort_done", done_a, 0);
    repeat (20) @(negedge rd_clk_tb);
    chk("abort_idle", busy_a, 0);
    run_a("after_abort", 1026);
    chk("after_abort_pass_held", pass_a, 1);

    // Start re-pulse mid-scan is ignored, then reset at address 500
    ram_a[6] = 8'h01;
    start_a = 1'b1;
    @(negedge rd_clk_tb);
    start_a = 1'b0;
    wait_addr_a(100);
    start_a = 1'b1;
    @(negedge rd_clk_tb);
    start_a = 1'b0;
    chk("repulse_addr", rd_addr_a, 101);
    chk("repulse_busy", busy_a, 1);
    wait_addr_a(500);
    chk("pre_rst_err_cnt", err_cnt_a, 1);
    chk("pre_rst_first", first_a, 6);
    #1 tb_rst = 1'b1;
    #1;
    chk("midrst_rd_addr", rd_addr_a, 0);
    chk("midrst_busy", busy_a, 0);
    chk("midrst_err_cnt", err_cnt_a, 0);
    chk("midrst_first", first_a, 0);
    chk("midrst_pass", pass_a, 0);
    chk("midrst_done", done_a, 0);
    @(negedge rd_clk_tb);
    tb_rst = 1'b0;
    repeat (5) @(negedge rd_clk_tb);
    chk("post_rst_busy", busy_a, 0);

    // RAM returns all zeros
    for (int a = 0; a < 1024; a++) ram_a[a] = 8'h00;
    run_a("zeros", 1026);

    // Unregistered RAM output: one DRAIN cycle, final address checked
    run_b("b_alt", 17);
    ram_b[15] = 8'h00;
    run_b("b_last", 17);

    repeat (5) @(negedge rd_clk_tb);
    chk("dones_a_total", dones_a, 4);
    chk("dones_b_total", dones_b, 2);
    chk("queue_a_empty", q_a.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
